alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the single-operation calculator ALU. Executes ADD, SUB, MUL and DIV on WIDTH-bit two's-complement operands. ADD/SUB take one cycle; MUL/DIV use an iterative shift datapath. It sits between the calculator's operand/operator registers and the display/result path, with ready/valid handshakes on both sides and overflow and error reporting.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/alu_muldiv_seq.sv | 117 +++++++++++
 rtl/alu_seq.sv | 156 +++++++++++++++
 tb/tb_alu_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator ALU: operation codes, FSM states
// and a small helper classifying the multi-cycle operations.
package calc_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_DIV  = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_iterative(input op_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative shift datapath shared by MUL (shift-add) and DIV (restoring),
// one bit per cycle on operand magnitudes, with sign fix-up on the way out.
module alu_muldiv_seq
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic             done_c,
    output logic [WIDTH-1:0] result_c,
    output logic             error_c
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [W2-1:0] acc;
    logic [W-1:0]  sh;
    logic [W-1:0]  opb;
    logic          div_q;
    logic          neg_q;
    logic          zero_q;

    logic [W-1:0]  left_mag;
    logic [W-1:0]  right_mag;
    logic [W:0]    mul_sum;
    logic [W:0]    div_rs;
    logic          div_ge;
    logic [W:0]    div_rem;
    logic [W2-1:0] acc_nx;
    logic [W-1:0]  sh_nx;
    logic [W2-1:0] prod;
    logic [W-1:0]  quo;

    // Magnitudes: MIN maps to 2^(W-1), which still fits as an unsigned W-bit value.
    assign left_mag  = left[W-1]  ? (~left  + W'(1)) : left;
    assign right_mag = right[W-1] ? (~right + W'(1)) : right;

    // One iteration: MUL adds into the upper half then shifts right;
    // DIV shifts the next dividend bit into the partial remainder and trial-subtracts.
    always_comb begin
        mul_sum = {1'b0, acc[W2-1:W]} + {1'b0, (sh[0] ? opb : W'(0))};
        div_rs  = {acc[W-1:0], sh[W-1]};
        div_ge  = (div_rs >= {1'b0, opb});
        div_rem = div_ge ? (div_rs - {1'b0, opb}) : div_rs;
        if (div_q) begin
            acc_nx = {(W - 1)'(0), div_rem};
            sh_nx  = {sh[W-2:0], div_ge};
        end else begin
            acc_nx = {mul_sum, acc[W-1:1]};
            sh_nx  = sh >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            sh     <= '0;
            opb    <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            sh     <= left_mag;
            opb    <= right_mag;
            div_q  <= is_div;
            neg_q  <= left[W-1] ^ right[W-1];
            zero_q <= (right == '0);
        end else if (busy) begin
            acc <= acc_nx;
            sh  <= sh_nx;
            if (cnt == LAST) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign done_c = busy && (cnt == LAST);

    // Sign fix-up and range checks on the settled registers.
    always_comb begin
        prod     = neg_q ? (~acc + W2'(1)) : acc;
        quo      = neg_q ? (~sh + W'(1)) : sh;
        result_c = '0;
        error_c  = 1'b0;
        if (div_q) begin
            if (zero_q) begin
                result_c = '0;
                error_c  = 1'b1;
            end else begin
                result_c = quo;
                error_c  = !neg_q && sh[W-1];
            end
        end else begin
            result_c = prod[W-1:0];
            error_c  = (prod[W2-1:W-1] != {(W + 1){prod[W-1]}});
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle calculator ALU: handshaked operand capture, single-cycle ADD/SUB,
// iterative MUL/DIV via alu_muldiv_seq, and registered result/error output.
module alu_seq
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] left_i,
    input  logic [WIDTH-1:0] right_i,
    input  op_t              op_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] result_o,
    output logic             error_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    localparam int unsigned W = WIDTH;

    state_t        state;
    state_t        state_nx;
    logic          accept_c;
    logic          md_start_c;
    logic          md_done_c;
    logic [W-1:0]  md_result_c;
    logic          md_error_c;

    logic [W-1:0]  left_q;
    logic [W-1:0]  right_q;
    op_t           op_q;

    logic [W-1:0]  sum_c;
    logic [W-1:0]  diff_c;
    logic          add_ovf_c;
    logic          sub_ovf_c;
    logic [W-1:0]  alu_result_c;
    logic          alu_error_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept_c = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (in_valid_i && !rst_i) begin
                    accept_c = 1'b1;
                    if (op_i == OP_MUL) begin
                        state_nx = S_MUL;
                    end else if (op_i == OP_DIV) begin
                        state_nx = S_DIV;
                    end else begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (md_done_c) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (out_valid_o && out_ready_i) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign in_ready_o = (state == S_IDLE) && !rst_i;
    assign md_start_c = accept_c && is_iterative(op_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            left_q  <= '0;
            right_q <= '0;
            op_q    <= OP_NONE;
        end else if (accept_c) begin
            left_q  <= left_i;
            right_q <= right_i;
            op_q    <= op_i;
        end
    end

    alu_muldiv_seq #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk      (clk_i),
        .rst      (rst_i),
        .start    (md_start_c),
        .is_div   (op_i == OP_DIV),
        .left     (left_i),
        .right    (right_i),
        .done_c   (md_done_c),
        .result_c (md_result_c),
        .error_c  (md_error_c)
    );

    // Signed overflow: operands agree (ADD) or differ (SUB) in sign and the result flips away from left.
    always_comb begin
        sum_c     = left_q + right_q;
        diff_c    = left_q - right_q;
        add_ovf_c = (left_q[W-1] == right_q[W-1]) && (sum_c[W-1] != left_q[W-1]);
        sub_ovf_c = (left_q[W-1] != right_q[W-1]) && (diff_c[W-1] != left_q[W-1]);
        alu_result_c = '0;
        alu_error_c  = 1'b0;
        case (op_q)
            OP_NONE: begin
                alu_result_c = '0;
                alu_error_c  = 1'b0;
            end
            OP_ADD: begin
                alu_result_c = sum_c;
                alu_error_c  = add_ovf_c;
            end
            OP_SUB: begin
                alu_result_c = diff_c;
                alu_error_c  = sub_ovf_c;
            end
            OP_MUL, OP_DIV: begin
                alu_result_c = md_result_c;
                alu_error_c  = md_error_c;
            end
            default: begin
                alu_result_c = '0;
                alu_error_c  = 1'b1;
            end
        endcase
    end

    // Result is loaded on the first cycle in S_DONE and held until consumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            result_o    <= '0;
            error_o     <= 1'b0;
        end else if ((state == S_DONE) && !out_valid_o) begin
            out_valid_o <= 1'b1;
            result_o    <= alu_result_c;
            error_o     <= alu_error_c;
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: directed corner cases plus random
// operations checked against an integer-arithmetic reference model.
module tb_alu_seq;
    import calc_pkg::*;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat;
        int           acc_cyc;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] left = '0;
    logic [W-1:0] right = '0;
    op_t          op = OP_NONE;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] result;
    logic         error;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   ready_mode = 0;
    exp_t exp_q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .left_i      (left),
        .right_i     (right),
        .op_i        (op),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .result_o    (result),
        .error_o     (error),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    // Reference model: exact integer arithmetic, then range check and wrap.
    function automatic void model(input int l, input int r, input op_t o,
                                  output logic [W-1:0] res, output logic err);
        int full;
        full = 0;
        res  = '0;
        err  = 1'b0;
        case (o)
            OP_NONE: begin res = '0; err = 1'b0; end
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                if (o == OP_DIV && r == 0) begin
                    res = '0;
                    err = 1'b1;
                end else begin
                    if (o == OP_ADD) full = l + r;
                    else if (o == OP_SUB) full = l - r;
                    else if (o == OP_MUL) full = l * r;
                    else full = l / r;
                    err = (full < -128) || (full > 127);
                    res = full[W-1:0];
                end
            end
            default: begin res = '0; err = 1'b1; end
        endcase
    endfunction

    task automatic do_op(input int l, input int r, input op_t o, input string name);
        exp_t e;
        int   k;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check({name, "_accept_timeout"}, 0, 1);
            return;
        end
        left     = W'(l);
        right    = W'(r);
        op       = o;
        in_valid = 1'b1;
        model(l, r, o, e.res, e.err);
        e.lat     = is_iterative(o) ? (W + 1) : 1;
        e.acc_cyc = cyc + 1;
        e.name    = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({name, "_ready_drop"}, int'(in_ready), 0);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    // Consumer: random acceptance, held low, or held high.
    initial begin
        forever begin
            @(negedge clk);
            if (ready_mode == 1) out_ready = 1'b0;
            else if (ready_mode == 2) out_ready = 1'b1;
            else out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops an expectation on each new result and checks it stays put.
    initial begin
        logic         prev_valid;
        logic [W-1:0] held_res;
        logic         held_err;
        exp_t         e;
        prev_valid = 1'b0;
        held_res   = '0;
        held_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: got result %0d error %0d, expected none", $signed(result), error);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, "_result"}, int'($signed(result)), int'($signed(e.res)));
                        check({e.name, "_error"}, int'(error), int'(e.err));
                        check({e.name, "_latency"}, cyc - e.acc_cyc, e.lat);
                    end
                    held_res = result;
                    held_err = error;
                end else if (out_valid && prev_valid) begin
                    check("hold_result", int'(result), int'(held_res));
                    check("hold_error", int'(error), int'(held_err));
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        int   l;
        int   r;
        int   sel;
        op_t  o;
        int   k;

        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_error", int'(error), 0);
        check("rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);

        do_op(100, 27, OP_ADD, "add_max");
        do_op(100, 28, OP_ADD, "add_ovf");
        do_op(-100, 29, OP_SUB, "sub_ovf");
        do_op(5, 9, OP_SUB, "sub_neg");
        do_op(-12, 10, OP_MUL, "mul_ok");
        do_op(-12, 11, OP_MUL, "mul_ovf");
        do_op(-7, 2, OP_DIV, "div_trunc");
        do_op(5, 0, OP_DIV, "div_zero");
        do_op(-128, -1, OP_DIV, "div_min");
        do_op(-128, 1, OP_DIV, "div_min_one");
        do_op(-128, 1, OP_MUL, "mul_min_one");
        do_op(42, 17, OP_NONE, "op_none");
        do_op(3, 4, op_t'(3'd6), "op_illegal");
        wait_drain("directed");

        // Backpressure: result held for 20 cycles, a stray in_valid is ignored.
        ready_mode = 1;
        do_op(3, 4, OP_ADD, "bp_add");
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("bp_valid_seen", int'(out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) begin
                left = 8'd1; right = 8'd1; op = OP_ADD; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            check("bp_in_ready_low", int'(in_ready), 0);
            check("bp_valid_held", int'(out_valid), 1);
        end
        in_valid   = 1'b0;
        ready_mode = 2;
        k = 0;
        while (out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("bp_released", int'(out_valid), 0);
        check("bp_ready_after_consume", int'(in_ready), 1);
        check("bp_stray_ignored", exp_q.size(), 0);
        do_op(-50, 20, OP_SUB, "bp_next");
        wait_drain("bp");

        // Reset in the middle of a multiply discards it.
        ready_mode = 0;
        do_op(7, 9, OP_MUL, "mul_aborted");
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready_in_rst", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        do_op(1, 1, OP_ADD, "add_after_rst");
        wait_drain("midrst");

        // Random operations with occasional corner operands.
        for (int i = 0; i < 80; i++) begin
            l = $signed(8'($urandom_range(0, 255)));
            r = $signed(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 7) == 0) r = 0;
            if ($urandom_range(0, 7) == 0) l = -128;
            if ($urandom_range(0, 7) == 0) r = -1;
            sel = $urandom_range(0, 11);
            if (sel < 2) o = OP_ADD;
            else if (sel < 4) o = OP_SUB;
            else if (sel < 7) o = OP_MUL;
            else if (sel < 10) o = OP_DIV;
            else if (sel < 11) o = OP_NONE;
            else o = op_t'(3'($urandom_range(5, 7)));
            do_op(l, r, o, "rand");
        end
        wait_drain("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
